// File: rtl/unidade_controle_jogo.sv
// Game round controller: Moore FSM sequencing a memory game round.
// Optional ESPERA timeout is built only when the TIMEOUT_EN macro is defined.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic       db_timeout
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } state_t;

  state_t r_state;

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;
  logic          r_timeout;
  logic          w_expired;

  assign w_expired  = (r_count == LAST);
  assign db_timeout = r_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign db_timeout       = 1'b0;
`endif

  // The timeout counter restarts on every entry into ESPERA; a move in the
  // expiry cycle takes priority over the timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= INICIAL;
`ifdef TIMEOUT_EN
      r_count   <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        INICIAL: begin
          if (iniciar) begin
            r_state <= PREPARACAO;
`ifdef TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        PREPARACAO: begin
          r_state <= ESPERA;
`ifdef TIMEOUT_EN
          r_count <= '0;
`endif
        end
        ESPERA: begin
`ifdef TIMEOUT_EN
          r_count <= r_count + ONE;
          if (jogada) begin
            r_state <= REGISTRA;
          end else if (w_expired) begin
            r_state   <= FIM_ERROU;
            r_timeout <= 1'b1;
          end
`else
          if (jogada) begin
            r_state <= REGISTRA;
          end
`endif
        end
        REGISTRA: begin
          r_state <= COMPARACAO;
        end
        COMPARACAO: begin
          if (!igual) begin
            r_state <= FIM_ERROU;
          end else if (fimC) begin
            r_state <= FIM_ACERTOU;
          end else begin
            r_state <= PROXIMO;
          end
        end
        PROXIMO: begin
          r_state <= ESPERA;
`ifdef TIMEOUT_EN
          r_count <= '0;
`endif
        end
        FIM_ACERTOU, FIM_ERROU: begin
          if (iniciar) begin
            r_state <= PREPARACAO;
`ifdef TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= INICIAL;
        end
      endcase
    end
  end

  // Moore decode: every strobe and status bit depends on the state alone.
  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    pronto    = 1'b0;
    db_estado = r_state;
    case (r_state)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA: begin
        registraR = 1'b1;
      end
      PROXIMO: begin
        contaC = 1'b1;
      end
      FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FIM_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 5000, number of clock cycles allowed in ESPERA before a timeout; effective only with TIMEOUT_EN.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 iniciar  input  1  level-sensitive request to start a round.
REQ-005 jogada  input  1  one-cycle pulse from the datapath edge detector: a move was made.
REQ-006 igual  input  1  datapath comparator result: registered move equals the memory word.
REQ-007 fimC  input  1  datapath address counter is at its last address.
REQ-008 zeraC  output  1  clear the address counter.
REQ-009 contaC  output  1  increment the address counter.
REQ-010 zeraR  output  1  clear the move register.
REQ-011 registraR  output  1  load the move register from the switches.
REQ-012 acertou  output  1  round ended with all moves correct.
REQ-013 errou  output  1  round ended with a wrong move or a timeout.
REQ-014 pronto  output  1  round ended, whether by acertou or errou.
REQ-015 db_estado  output  4  current state code, for the 7-segment debug display.
REQ-016 db_timeout  output  1  last round ended by timeout; driven 0 without TIMEOUT_EN.

Function
REQ-017 Moore FSM; all outputs are decoded from the registered state only, except db_timeout, which is a register.
REQ-018 State codes: INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTOU=A, FIM_ERROU=E (hex); db_estado equals the current code.
REQ-019 Transitions from INICIAL: iniciar=1 -> PREPARACAO; otherwise stay.
REQ-020 PREPARACAO: zeraC=1, zeraR=1; unconditional move to ESPERA after 1 cycle; clears db_timeout.
REQ-021 ESPERA: jogada=1 -> REGISTRA; otherwise stay.
REQ-022 REGISTRA: registraR=1; unconditional move to COMPARACAO (1 cycle).
REQ-023 COMPARACAO transitions: igual=0 -> FIM_ERROU; igual=1 and fimC=1 -> FIM_ACERTOU; igual=1 and fimC=0 -> PROXIMO.
REQ-024 PROXIMO: contaC=1; unconditional move to ESPERA (1 cycle).
REQ-025 FIM_ACERTOU: acertou=1, pronto=1. FIM_ERROU: errou=1, pronto=1. Both -> PREPARACAO on iniciar=1, else hold.
REQ-026 In every state other than those listed in REQ-020, REQ-022 and REQ-024, the control strobes zeraC, contaC, zeraR and registraR are 0.
REQ-027 Latency: 3 cycles from the cycle jogada is sampled to the PROXIMO, FIM_ACERTOU or FIM_ERROU state.
REQ-028 jogada is ignored in every state except ESPERA.
REQ-029 Unused state encodings return to INICIAL on the next clock edge.

Reset
REQ-030 reset=0 at a rising edge forces INICIAL and clears the timeout counter and db_timeout; this overrides every other input.
REQ-031 Values during reset: all outputs 0 and db_estado=0; this applies from any state, including mid-round.

Configuration
REQ-032 Macro TIMEOUT_EN defined: a timeout counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entry to ESPERA and increments each cycle while in ESPERA.
REQ-033 Timeout expiry: when the counter reaches TIMEOUT_CYCLES-1 with jogada=0, go to FIM_ERROU and set db_timeout=1; if jogada=1 in that same cycle, jogada wins and the FSM goes to REGISTRA.
REQ-034 Macro TIMEOUT_EN undefined: no timeout counter is built, ESPERA waits indefinitely, and db_timeout is tied to 0.

Verification
REQ-035 Reset then iniciar=1 for 5 cycles -> db_estado 0 -> 1 -> 2; zeraC=zeraR=1 for exactly 1 cycle.
REQ-036 Four jogada pulses, igual=1 each time, fimC=1 on the 4th -> contaC pulses 3 times; FIM_ACERTOU with acertou=1, pronto=1, db_estado=A.
REQ-037 Three correct moves, then a 4th with igual=0 -> FIM_ERROU with errou=1, pronto=1, db_estado=E, db_timeout=0.
REQ-038 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no jogada -> FIM_ERROU exactly 16 cycles after entering ESPERA, db_timeout=1; second run with jogada on cycle 16 -> REGISTRA.
REQ-039 reset=0 asserted in COMPARACAO -> INICIAL on the next edge with all outputs 0; a following iniciar restarts normally.
REQ-040 jogada pulses while in INICIAL or FIM_ACERTOU -> no state change and registraR stays 0.
